// File: rtl/simeck32_key_expander.sv
`default_nettype none
// ============================================================================
//  Module      : simeck32_key_expander
//  Description : Simeck32/64 round-key generator. A master key is expanded
//                once into a 32-entry key buffer (32 cycles), then streamed
//                over a valid/ready interface in forward (encrypt) or reverse
//                (decrypt) order. A stored key set can be replayed without
//                re-expansion.
//  Ports       : clk        rising-edge clock
//                rst        synchronous active-high reset
//                key_in     master key {t2,t1,t0,k0}
//                key_load   start expansion of key_in
//                mode       0 = round 0..31, 1 = round 31..0
//                rk_replay  re-stream stored keys (honoured in HOLD only)
//                rk_ready   downstream accepts the current key
//                rk_out     round key, rk_idx its round index
//                rk_valid   rk_out/rk_idx valid, rk_last final beat
//                busy       expansion in progress
//                keys_held  full key set stored, stream finished
//  Revision    : 1.0  initial release
// ============================================================================
module simeck32_key_expander #(
    parameter int ROUNDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        key_load,
    input  logic        mode,
    input  logic        rk_replay,
    input  logic        rk_ready,
    output logic [15:0] rk_out,
    output logic [4:0]  rk_idx,
    output logic        rk_valid,
    output logic        rk_last,
    output logic        busy,
    output logic        keys_held
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_EXPAND = 2'd1;
    localparam logic [1:0] c_SERVE  = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    localparam logic [4:0]  c_LAST_IDX = 5'(ROUNDS - 1);
    localparam logic [15:0] c_CONST    = 16'hFFFC;
    localparam logic [4:0]  c_LFSR_INIT = 5'b11111;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    logic [4:0]  r_round;
    logic [4:0]  r_lfsr;
    logic [15:0] r_k;
    logic [15:0] r_t0;
    logic [15:0] r_t1;
    logic [15:0] r_t2;
    logic        r_mode;
    logic [4:0]  r_idx;
    logic [15:0] r_buf [ROUNDS];

    logic        w_accept_load;
    logic        w_handshake;
    logic        w_end_idx;
    logic [15:0] w_rot5;
    logic [15:0] w_rot1;
    logic [15:0] w_new_t;
    logic        w_lfsr_fb;

    // key_load is honoured everywhere except mid-expansion, and always wins
    // over rk_replay.
    assign w_accept_load = key_load && (r_state != c_EXPAND);
    assign w_handshake   = (r_state == c_SERVE) && rk_ready;
    assign w_end_idx     = r_mode ? (r_idx == 5'd0) : (r_idx == c_LAST_IDX);

    // One round of the key schedule; the round constant bit z_i is the LFSR
    // output s[0] and only touches bit 0.
    assign w_rot5    = {r_t0[10:0], r_t0[15:11]};
    assign w_rot1    = {r_t0[14:0], r_t0[15]};
    assign w_new_t   = r_k ^ (r_t0 & w_rot5) ^ w_rot1 ^ c_CONST ^ {15'd0, r_lfsr[0]};
    assign w_lfsr_fb = r_lfsr[2] ^ r_lfsr[0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept_load) w_next_state = c_EXPAND;
            end
            c_EXPAND: begin
                if (r_round == c_LAST_IDX) w_next_state = c_SERVE;
            end
            c_SERVE: begin
                if (w_accept_load) begin
                    w_next_state = c_EXPAND;
                end else if (w_handshake && w_end_idx) begin
                    w_next_state = c_HOLD;
                end
            end
            c_HOLD: begin
                if (w_accept_load) begin
                    w_next_state = c_EXPAND;
                end else if (rk_replay) begin
                    w_next_state = c_SERVE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        rk_valid  = (r_state == c_SERVE);
        rk_last   = (r_state == c_SERVE) && w_end_idx;
        busy      = (r_state == c_EXPAND);
        keys_held = (r_state == c_HOLD);
        rk_idx    = r_idx;
        // Gated so the buffer (never reset) is not visible before a full
        // expansion has filled it.
        rk_out    = (r_state == c_SERVE) ? r_buf[r_idx] : 16'h0000;
    end

    // ------------------------------------------------------------------
    // Schedule datapath, round counter, stream index and latched mode
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_round <= 5'd0;
            r_lfsr  <= c_LFSR_INIT;
            r_k     <= 16'h0000;
            r_t0    <= 16'h0000;
            r_t1    <= 16'h0000;
            r_t2    <= 16'h0000;
            r_mode  <= 1'b0;
            r_idx   <= 5'd0;
        end else if (w_accept_load) begin
            r_round <= 5'd0;
            r_lfsr  <= c_LFSR_INIT;
            r_k     <= key_in[15:0];
            r_t0    <= key_in[31:16];
            r_t1    <= key_in[47:32];
            r_t2    <= key_in[63:48];
            r_mode  <= mode;
        end else begin
            case (r_state)
                c_EXPAND: begin
                    r_k     <= r_t0;
                    r_t0    <= r_t1;
                    r_t1    <= r_t2;
                    r_t2    <= w_new_t;
                    r_lfsr  <= {w_lfsr_fb, r_lfsr[4:1]};
                    r_round <= r_round + 5'd1;
                    if (r_round == c_LAST_IDX) begin
                        r_idx <= r_mode ? c_LAST_IDX : 5'd0;
                    end
                end
                c_SERVE: begin
                    // The index freezes on the final beat; the FSM leaves
                    // SERVE on that handshake.
                    if (w_handshake && !w_end_idx) begin
                        r_idx <= r_mode ? (r_idx - 5'd1) : (r_idx + 5'd1);
                    end
                end
                c_HOLD: begin
                    if (rk_replay) begin
                        r_mode <= mode;
                        r_idx  <= mode ? c_LAST_IDX : 5'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key buffer: k_i lands at index i during expansion cycle i
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && (r_state == c_EXPAND)) begin
            r_buf[r_round] <= r_k;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simeck32_key_expander.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simeck32_key_expander
//  Description : Directed self-checking bench for simeck32_key_expander with
//                an independent array-form model of the Simeck32/64 schedule.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_simeck32_key_expander;

    logic        clk;
    logic        rst;
    logic [63:0] key_in;
    logic        key_load;
    logic        mode;
    logic        rk_replay;
    logic        rk_ready;
    logic [15:0] rk_out;
    logic [4:0]  rk_idx;
    logic        rk_valid;
    logic        rk_last;
    logic        busy;
    logic        keys_held;

    int total;
    int bad;

    logic [15:0] exp_rk  [32];
    logic [15:0] got_key [32];

    simeck32_key_expander #(.ROUNDS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_load  (key_load),
        .mode      (mode),
        .rk_replay (rk_replay),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_last   (rk_last),
        .busy      (busy),
        .keys_held (keys_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] x, input int r);
        return (x << r) | (x >> (16 - r));
    endfunction

    // Reference schedule written in indexed-recurrence form.
    task automatic build_model(input logic [63:0] key);
        logic [15:0] k [36];
        logic [15:0] t [36];
        logic        s [40];
        k[0] = key[15:0];
        t[0] = key[31:16];
        t[1] = key[47:32];
        t[2] = key[63:48];
        for (int i = 0; i < 5; i++) s[i] = 1'b1;
        for (int i = 0; i < 32; i++) s[i+5] = s[i+2] ^ s[i];
        for (int i = 0; i < 32; i++) begin
            t[i+3] = k[i] ^ (t[i] & rotl(t[i], 5)) ^ rotl(t[i], 1) ^ 16'hFFFC ^ {15'd0, s[i]};
            k[i+1] = t[i];
        end
        for (int i = 0; i < 32; i++) exp_rk[i] = k[i];
    endtask

    task automatic load(input logic [63:0] key, input logic m);
        key_in   = key;
        mode     = m;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // Entered one cycle after the load edge. Optionally pulses a second
    // key_load at a chosen expansion cycle.
    task automatic wait_serve(input int glitch_at, input logic [63:0] gkey);
        int nbusy;
        int lat;
        nbusy = 0;
        lat   = 1;
        while (!rk_valid && lat < 200) begin
            if (busy) nbusy++;
            if (rk_last) chk("last_while_busy", rk_last, 0);
            if (lat == glitch_at) begin
                key_in   = gkey;
                key_load = 1'b1;
            end else begin
                key_load = 1'b0;
            end
            tick();
            lat++;
        end
        key_load = 1'b0;
        chk("busy_cycles", nbusy, 32);
        chk("load_latency", lat, 33);
    endtask

    task automatic collect(input int pct, input logic m);
        int beats;
        int cyc;
        int errs_val;
        int errs_stab;
        logic        held;
        logic [15:0] h_out;
        logic [4:0]  h_idx;
        logic        h_last;
        logic [4:0]  ei;
        beats = 0; cyc = 0; errs_val = 0; errs_stab = 0; held = 1'b0;
        h_out = '0; h_idx = '0; h_last = 1'b0;
        while (beats < 32 && cyc < 2000) begin
            rk_ready = ($urandom_range(0, 99) < pct);
            if (held && (!rk_valid || rk_out !== h_out || rk_idx !== h_idx || rk_last !== h_last))
                errs_stab++;
            if (rk_valid) begin
                ei = m ? 5'(31 - beats) : 5'(beats);
                if (rk_idx !== ei || rk_out !== exp_rk[ei] || rk_last !== (beats == 31))
                    errs_val++;
                if (rk_ready) begin
                    got_key[beats] = rk_out;
                    beats++;
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    h_out  = rk_out;
                    h_idx  = rk_idx;
                    h_last = rk_last;
                end
            end else begin
                errs_val++;
            end
            tick();
            cyc++;
        end
        rk_ready = 1'b0;
        chk("beat_count", beats, 32);
        chk("beat_values", errs_val, 0);
        chk("stall_stable", errs_stab, 0);
        chk("valid_after_last", rk_valid, 0);
        chk("keys_held", keys_held, 1);
    endtask

    initial begin
        logic [63:0] k;
        total = 0; bad = 0;
        key_in = '0; key_load = 0; mode = 0; rk_replay = 0; rk_ready = 0;

        // Reset with random inputs.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            key_in    = {$urandom, $urandom};
            key_load  = 1'($urandom_range(0, 1));
            mode      = 1'($urandom_range(0, 1));
            rk_replay = 1'($urandom_range(0, 1));
            rk_ready  = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_rk_out", rk_out, 0);
        chk("rst_rk_idx", rk_idx, 0);
        chk("rst_rk_valid", rk_valid, 0);
        chk("rst_rk_last", rk_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_keys_held", keys_held, 0);
        rk_replay = 0; rk_ready = 0;

        // Forward stream, load right after release.
        rst = 1'b0;
        build_model(64'h1918111009080100);
        load(64'h1918111009080100, 1'b0);
        chk("busy_after_release", busy, 1);
        wait_serve(-1, '0);
        chk("fwd_first_idx", rk_idx, 0);
        collect(100, 1'b0);
        chk("fwd_k0", got_key[0], 16'h0100);
        chk("fwd_k1", got_key[1], 16'h0908);
        chk("fwd_k2", got_key[2], 16'h1110);
        chk("fwd_k3", got_key[3], 16'h1918);

        // Reverse replay.
        rk_replay = 1'b1;
        mode      = 1'b1;
        tick();
        rk_replay = 1'b0;
        chk("replay_valid", rk_valid, 1);
        chk("replay_first_idx", rk_idx, 31);
        collect(100, 1'b1);
        chk("rev_k3", got_key[28], 16'h1918);
        chk("rev_k2", got_key[29], 16'h1110);
        chk("rev_k1", got_key[30], 16'h0908);
        chk("rev_k0", got_key[31], 16'h0100);

        // key_load beats rk_replay in HOLD; key 0 under backpressure.
        build_model(64'h0);
        key_in    = 64'h0;
        mode      = 1'b0;
        key_load  = 1'b1;
        rk_replay = 1'b1;
        tick();
        key_load  = 1'b0;
        rk_replay = 1'b0;
        chk("prio_busy", busy, 1);
        chk("prio_valid", rk_valid, 0);
        wait_serve(-1, '0);
        collect(50, 1'b0);

        // All-ones and random keys under backpressure, alternating order.
        for (int i = 1; i < 10; i++) begin
            k = (i == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            build_model(k);
            load(k, 1'(i));
            wait_serve(-1, '0);
            collect(50, 1'(i));
        end

        // key_load during expansion cycle 10 is ignored.
        k = 64'h0123_4567_89AB_CDEF;
        build_model(k);
        load(k, 1'b0);
        wait_serve(10, 64'hDEAD_BEEF_CAFE_F00D);
        collect(100, 1'b0);

        // key_load at serve beat 5 aborts and restarts.
        k = 64'h1111_2222_3333_4444;
        build_model(k);
        load(k, 1'b0);
        wait_serve(-1, '0);
        rk_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_at_idx", rk_idx, 5);
        k = 64'hA5A5_5A5A_0F0F_F0F0;
        build_model(k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        rk_ready = 1'b0;
        chk("abort_valid_drop", rk_valid, 0);
        chk("abort_busy", busy, 1);
        wait_serve(-1, '0);
        collect(100, 1'b0);

        // Reset at expansion cycle 20.
        load(64'h7777_6666_5555_4444, 1'b0);
        for (int i = 1; i < 20; i++) tick();
        chk("mid_expand_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", rk_valid, 0);
        chk("mid_rst_held", keys_held, 0);
        chk("mid_rst_idx", rk_idx, 0);

        // rk_replay in IDLE has no effect.
        rk_replay = 1'b1;
        tick();
        tick();
        rk_replay = 1'b0;
        chk("idle_replay_valid", rk_valid, 0);
        chk("idle_replay_busy", busy, 0);
        chk("idle_replay_held", keys_held, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simeck32_key_expander.md
SIMECK32_KEY_EXPANDER -- requirements
Module: simeck32_key_expander

Interface
REQ-001 Parameter: ROUNDS, default 32, number of Simeck32/64 round keys generated; 32 is the only supported value.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; all ports are listed below.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 key_in  input  64  master key {t2,t1,t0,k0}, 16 bits each, with k0 = key_in[15:0].
REQ-006 key_load  input  1  single-cycle request to start expanding key_in.
REQ-007 mode  input  1  stream order: 0 = round 0..31 (encrypt); 1 = round 31..0 (decrypt).
REQ-008 rk_replay  input  1  re-stream stored keys without re-expansion.
REQ-009 rk_ready  input  1  downstream accepts rk_out.
REQ-010 rk_out  output  16  round key.
REQ-011 rk_idx  output  5  round index of rk_out.
REQ-012 rk_valid  output  1  rk_out/rk_idx are valid.
REQ-013 rk_last  output  1  current beat is the final key of the stream.
REQ-014 busy  output  1  high while expanding.
REQ-015 keys_held  output  1  high in HOLD (a full key set is stored and idle).

Function
REQ-016 The FSM SHALL have the states IDLE, EXPAND, SERVE and HOLD.
REQ-017 The block SHALL run the Simeck32/64 schedule as follows:
- k_{i+1} = t_i.
- t_{i+3} = k_i ^ (t_i & rotl(t_i,5)) ^ rotl(t_i,1) ^ 0xFFFC ^ z_i, with z_i XORed into bit 0 only.
REQ-018 z_i SHALL be bit s[0] of a 5-bit LFSR loaded with 5'b11111 on each accepted key_load, advancing once per EXPAND cycle, with the new bit s_{i+5} = s_{i+2} ^ s_i.
REQ-019 key_load in IDLE, SERVE or HOLD SHALL be accepted: next cycle EXPAND, round counter 0, mode latched.
REQ-020 key_load in EXPAND SHALL be ignored.
REQ-021 EXPAND SHALL last exactly 32 cycles and write k_i into a 32x16 buffer at index i in cycle i.
REQ-022 busy SHALL be 1 exactly during EXPAND.
REQ-023 Load latency: key_load sampled at edge N -> busy for cycles N+1..N+32 -> SERVE with rk_valid=1 from cycle N+33.
REQ-024 In SERVE, rk_idx SHALL start at 0 (mode 0) or 31 (mode 1) and step ±1 on each cycle with rk_valid & rk_ready.
REQ-025 rk_out SHALL equal buffer[rk_idx].
REQ-026 While rk_valid & !rk_ready, rk_out, rk_idx and rk_last SHALL hold stable, with no skipped or duplicated index.
REQ-027 rk_last SHALL be 1 only while rk_valid and rk_idx = 31 (mode 0) or 0 (mode 1).
REQ-028 The handshake on the last beat SHALL move to HOLD, with rk_valid=0 the next cycle.
REQ-029 rk_replay in HOLD SHALL re-latch mode and enter SERVE next cycle; rk_replay in any other state SHALL be ignored.
REQ-030 key_load during SERVE SHALL abort the stream: rk_valid=0 next cycle, and the buffer is fully rewritten.
REQ-031 Simultaneous key_load and rk_replay SHALL give key_load priority.
REQ-032 In IDLE, EXPAND and HOLD, rk_valid and rk_last SHALL be 0.

Reset
REQ-033 When rst=1 at a rising edge, the block SHALL enter IDLE with rk_out=0, rk_idx=0, rk_valid=0, rk_last=0, busy=0, keys_held=0, LFSR=5'b11111 and round counter 0.
REQ-034 Reset SHALL leave buffer contents undefined and SHALL never be read before a completed EXPAND.
REQ-035 Reset mid-EXPAND or mid-SERVE SHALL abort to IDLE at that edge.

Verification
REQ-036 Reset: assert rst 2 cycles with random inputs -> all outputs 0; key_load on the first cycle after release -> busy next cycle.
REQ-037 Forward order: key_in=0x1918111009080100, mode=0, rk_ready=1.
- busy for 32 cycles; rk_valid 33 cycles after load.
- First beats (idx 0..3) = 0x0100, 0x0908, 0x1110, 0x1918.
- 32 beats total; rk_last on idx 31; keys_held follows.
REQ-038 Reverse replay: after REQ-037, rk_replay with mode=1.
- idx 31 down to 0.
- Last four beats = 0x1918, 0x1110, 0x0908, 0x0100; rk_last on idx 0.
- Sequence equals the reversed forward sequence.
REQ-039 Backpressure: random rk_ready (~50%) -> outputs stable while stalled; exactly 32 handshakes with monotonic idx; matches a software reference model for keys 0x0, all-ones and 8 random keys.
REQ-040 Interference cases:
- key_load at EXPAND cycle 10 -> ignored; 32 busy cycles total.
- key_load at SERVE beat 5 -> rk_valid drops next cycle; new key expanded and streamed from start.
- rst at EXPAND cycle 20 -> IDLE.
- rk_replay in IDLE -> no effect.
